axi4_b_sender_arb: RTL and testbench

Write-response (B) channel merger for the RAB slave port. It returns locally generated responses for dropped write transactions (RAB miss, multi-hit, protection violation, prefetch) and forwards real B responses from the master port onto the single slave port. Successor to the single-source drop sender, with these additions:
- parametrised drop-queue depth and miss response code;
- fair round-robin arbitration between the two sources;
- AXI-compliant payload stability (no source switch while `s_axi4_bvalid` is pending);
- occupancy and drop-count observability.

---
 rtl/axi4_b_sender_arb.sv | 113 +++++++++++
 tb/tb_axi4_b_sender_arb.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_b_sender_arb.sv
// axi4_b_sender_arb: merges queued dropped-write responses and forwarded master B responses onto one slave B port
module axi4_b_sender_arb #(
    parameter int          AXI_ID_WIDTH   = 10,
    parameter int          AXI_USER_WIDTH = 4,
    parameter int          DROP_DEPTH     = 4,
    parameter logic [1:0]  MISS_RESP      = 2'b10,
    parameter int          CNT_WIDTH      = 16
) (
    input  logic                            axi4_aclk,
    input  logic                            axi4_arstn,
    input  logic                            drop_i,
    output logic                            done_o,
    input  logic [AXI_ID_WIDTH-1:0]         id_i,
    input  logic                            prefetch_i,
    input  logic                            hit_i,
    output logic [AXI_ID_WIDTH-1:0]         s_axi4_bid,
    output logic [1:0]                      s_axi4_bresp,
    output logic                            s_axi4_bvalid,
    output logic [AXI_USER_WIDTH-1:0]       s_axi4_buser,
    input  logic                            s_axi4_bready,
    input  logic [AXI_ID_WIDTH-1:0]         m_axi4_bid,
    input  logic [1:0]                      m_axi4_bresp,
    input  logic                            m_axi4_bvalid,
    input  logic [AXI_USER_WIDTH-1:0]       m_axi4_buser,
    output logic                            m_axi4_bready,
    input  logic                            clr_cnt_i,
    output logic [CNT_WIDTH-1:0]            drop_cnt_o,
    output logic [$clog2(DROP_DEPTH):0]     fifo_level_o
);
    localparam int AW = $clog2(DROP_DEPTH);
    localparam int LW = AW + 1;
    localparam int EW = AXI_ID_WIDTH + 2;

    typedef enum logic [1:0] {IDLE, LOCK_DROP, LOCK_FWD} state_t;

    state_t                r_state, w_next;
    logic [EW-1:0]         r_mem [DROP_DEPTH];
    logic [AW-1:0]         r_wptr, r_rptr;
    logic [LW-1:0]         r_level;
    logic                  r_last_fwd;
    logic [CNT_WIDTH-1:0]  r_cnt;
    logic [EW-1:0]         w_head;
    logic                  w_push, w_pop, w_hs, w_d, w_f, w_gnt_drop, w_gnt_fwd;

    assign w_push       = drop_i & (r_level < LW'(DROP_DEPTH));
    assign done_o       = w_push;
    assign w_head       = r_mem[r_rptr];
    assign w_d          = r_level != '0;
    assign w_f          = m_axi4_bvalid;
    // In IDLE a tie goes to whichever source did not win the last handshake
    assign w_gnt_drop   = (r_state == LOCK_DROP) | ((r_state == IDLE) & w_d & (~w_f | r_last_fwd));
    assign w_gnt_fwd    = (r_state == LOCK_FWD)  | ((r_state == IDLE) & w_f & (~w_d | ~r_last_fwd));
    assign w_pop        = w_gnt_drop & s_axi4_bready;
    assign w_hs         = s_axi4_bvalid & s_axi4_bready;
    assign drop_cnt_o   = r_cnt;
    assign fifo_level_o = r_level;

    always_ff @(posedge axi4_aclk or negedge axi4_arstn) begin
        if (!axi4_arstn) r_state <= IDLE;
        else             r_state <= w_next;
    end

    always_comb begin
        w_next = IDLE;
        case (r_state)
            IDLE:      w_next = (w_gnt_drop & ~s_axi4_bready) ? LOCK_DROP :
                                (w_gnt_fwd  & ~s_axi4_bready) ? LOCK_FWD  : IDLE;
            LOCK_DROP: w_next = w_hs ? IDLE : LOCK_DROP;
            LOCK_FWD:  w_next = w_hs ? IDLE : LOCK_FWD;
            default:   w_next = IDLE;
        endcase
    end

    always_comb begin
        s_axi4_bvalid = 1'b0;
        s_axi4_bid    = '0;
        s_axi4_bresp  = 2'b00;
        s_axi4_buser  = '0;
        m_axi4_bready = 1'b0;
        if (w_gnt_drop) begin
            s_axi4_bvalid = 1'b1;
            s_axi4_bid    = w_head[AXI_ID_WIDTH-1:0];
            s_axi4_bresp  = (w_head[EW-1] & w_head[EW-2]) ? 2'b00 : MISS_RESP;
        end else if (w_gnt_fwd) begin
            s_axi4_bvalid = m_axi4_bvalid;
            s_axi4_bid    = m_axi4_bid;
            s_axi4_bresp  = m_axi4_bresp;
            s_axi4_buser  = m_axi4_buser;
            m_axi4_bready = s_axi4_bready;
        end
    end

    always_ff @(posedge axi4_aclk) begin
        if (w_push) r_mem[r_wptr] <= {prefetch_i, hit_i, id_i};
    end

    always_ff @(posedge axi4_aclk or negedge axi4_arstn) begin
        if (!axi4_arstn) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_level    <= '0;
            r_last_fwd <= 1'b1;
            r_cnt      <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            r_level <= r_level + LW'(w_push) - LW'(w_pop);
            if (w_hs) r_last_fwd <= w_gnt_fwd;
            if (clr_cnt_i)             r_cnt <= '0;
            else if (w_pop & ~&r_cnt)  r_cnt <= r_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_axi4_b_sender_arb.sv
// tb_axi4_b_sender_arb: directed bench with a B-beat scoreboard for axi4_b_sender_arb
module tb_axi4_b_sender_arb;
    logic        axi4_aclk = 1'b0;
    logic        axi4_arstn;
    logic        drop_i, prefetch_i, hit_i, clr_cnt_i;
    logic [9:0]  id_i;
    logic        done_o;
    logic [9:0]  s_bid, m_bid;
    logic [1:0]  s_bresp, m_bresp;
    logic        s_bvalid, s_bready, m_bvalid, m_bready;
    logic [3:0]  s_buser, m_buser;
    logic [15:0] drop_cnt;
    logic [2:0]  level;
    logic        sat_done, sat_bvalid, sat_mready;
    logic [9:0]  sat_bid;
    logic [1:0]  sat_bresp, sat_cnt;
    logic [3:0]  sat_buser;
    logic [2:0]  sat_level;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct packed {logic [9:0] id; logic [1:0] resp; logic [3:0] user;} beat_t;
    beat_t sb[$];

    always #5 axi4_aclk = ~axi4_aclk;

    axi4_b_sender_arb dut (
        .axi4_aclk(axi4_aclk), .axi4_arstn(axi4_arstn),
        .drop_i(drop_i), .done_o(done_o), .id_i(id_i), .prefetch_i(prefetch_i), .hit_i(hit_i),
        .s_axi4_bid(s_bid), .s_axi4_bresp(s_bresp), .s_axi4_bvalid(s_bvalid), .s_axi4_buser(s_buser),
        .s_axi4_bready(s_bready),
        .m_axi4_bid(m_bid), .m_axi4_bresp(m_bresp), .m_axi4_bvalid(m_bvalid), .m_axi4_buser(m_buser),
        .m_axi4_bready(m_bready),
        .clr_cnt_i(clr_cnt_i), .drop_cnt_o(drop_cnt), .fifo_level_o(level)
    );

    axi4_b_sender_arb #(.CNT_WIDTH(2)) u_sat (
        .axi4_aclk(axi4_aclk), .axi4_arstn(axi4_arstn),
        .drop_i(drop_i), .done_o(sat_done), .id_i(id_i), .prefetch_i(prefetch_i), .hit_i(hit_i),
        .s_axi4_bid(sat_bid), .s_axi4_bresp(sat_bresp), .s_axi4_bvalid(sat_bvalid), .s_axi4_buser(sat_buser),
        .s_axi4_bready(s_bready),
        .m_axi4_bid(m_bid), .m_axi4_bresp(m_bresp), .m_axi4_bvalid(m_bvalid), .m_axi4_buser(m_buser),
        .m_axi4_bready(sat_mready),
        .clr_cnt_i(clr_cnt_i), .drop_cnt_o(sat_cnt), .fifo_level_o(sat_level)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge axi4_aclk);
        #1;
    endtask

    task automatic set_drop(input logic en, input logic [9:0] id, input logic pf, input logic hit);
        drop_i = en; id_i = id; prefetch_i = pf; hit_i = hit;
    endtask

    always @(negedge axi4_aclk) begin
        if (axi4_arstn && s_bvalid && s_bready) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_errors++;
                $error("FAIL sb_unexpected: observed bid 0x%0h expected no beat", s_bid);
            end else begin
                beat_t e;
                e = sb.pop_front();
                chk("sb_bid", 32'(s_bid), 32'(e.id));
                chk("sb_bresp", 32'(s_bresp), 32'(e.resp));
                chk("sb_buser", 32'(s_buser), 32'(e.user));
            end
        end
    end

    initial begin
        axi4_arstn = 1'b0;
        set_drop(1'b0, 10'h0, 1'b0, 1'b0);
        clr_cnt_i = 1'b0;
        s_bready = 1'b0;
        m_bvalid = 1'b0; m_bid = '0; m_bresp = '0; m_buser = '0;
        #2;
        m_bvalid = 1'b1; m_bid = 10'h33; s_bready = 1'b1;
        #1;
        chk("rst_bvalid_transparent", 32'(s_bvalid), 32'd1);
        chk("rst_bid_transparent", 32'(s_bid), 32'h33);
        chk("rst_mready_transparent", 32'(m_bready), 32'd1);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_cnt", 32'(drop_cnt), 32'd0);
        chk("rst_done", 32'(done_o), 32'd0);
        m_bvalid = 1'b0; m_bid = '0; s_bready = 1'b0;
        step; step;
        axi4_arstn = 1'b1;
        step;

        // single drop, prefetch+hit gives OKAY
        set_drop(1'b1, 10'h15, 1'b1, 1'b1);
        s_bready = 1'b1;
        sb.push_back('{10'h15, 2'b00, 4'h0});
        #1 chk("single_done", 32'(done_o), 32'd1);
        step;
        set_drop(1'b0, 10'h0, 1'b0, 1'b0);
        #1;
        chk("single_bvalid", 32'(s_bvalid), 32'd1);
        chk("single_bid", 32'(s_bid), 32'h15);
        step;
        chk("single_cnt", 32'(drop_cnt), 32'd1);
        chk("single_level", 32'(level), 32'd0);
        s_bready = 1'b0;

        // full queue refuses the fifth drop
        for (int i = 1; i <= 5; i++) begin
            set_drop(1'b1, 10'(i), 1'b0, 1'b0);
            #1 chk("full_done", 32'(done_o), (i <= 4) ? 32'd1 : 32'd0);
            if (i <= 4) sb.push_back('{10'(i), 2'b10, 4'h0});
            step;
        end
        set_drop(1'b0, 10'h0, 1'b0, 1'b0);
        chk("full_level", 32'(level), 32'd4);
        s_bready = 1'b1;
        step; step; step; step;
        chk("drain_level", 32'(level), 32'd0);
        chk("drain_cnt", 32'(drop_cnt), 32'd5);
        chk("sat_cnt_after5", 32'(sat_cnt), 32'd3);
        s_bready = 1'b0;

        // a forward-only handshake makes forward the last winner
        m_bvalid = 1'b1; m_bid = 10'h7; m_bresp = 2'b01; m_buser = 4'h5; s_bready = 1'b1;
        sb.push_back('{10'h7, 2'b01, 4'h5});
        #1 chk("fwd_mready", 32'(m_bready), 32'd1);
        step;
        m_bvalid = 1'b0; s_bready = 1'b0;

        // tie arbitration: A, 7, B, 7
        set_drop(1'b1, 10'h0A, 1'b0, 1'b0); step;
        set_drop(1'b1, 10'h0B, 1'b0, 1'b0); step;
        set_drop(1'b0, 10'h0, 1'b0, 1'b0);
        sb.push_back('{10'h0A, 2'b10, 4'h0});
        sb.push_back('{10'h7, 2'b01, 4'h5});
        sb.push_back('{10'h0B, 2'b10, 4'h0});
        sb.push_back('{10'h7, 2'b01, 4'h5});
        m_bvalid = 1'b1; s_bready = 1'b1;
        #1;
        chk("tie1_bid", 32'(s_bid), 32'h0A);
        chk("tie1_mready", 32'(m_bready), 32'd0);
        step;
        chk("tie2_bid", 32'(s_bid), 32'h7);
        chk("tie2_mready", 32'(m_bready), 32'd1);
        step;
        chk("tie3_bid", 32'(s_bid), 32'h0B);
        step;
        chk("tie4_bid", 32'(s_bid), 32'h7);
        step;
        m_bvalid = 1'b0; s_bready = 1'b0;

        // drop payload held under backpressure while master becomes valid
        set_drop(1'b1, 10'h21, 1'b1, 1'b0);
        sb.push_back('{10'h21, 2'b10, 4'h0});
        step;
        set_drop(1'b0, 10'h0, 1'b0, 1'b0);
        m_bvalid = 1'b1; m_bid = 10'h3C; m_bresp = 2'b00; m_buser = 4'h9;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("hold_bvalid", 32'(s_bvalid), 32'd1);
            chk("hold_bid", 32'(s_bid), 32'h21);
            chk("hold_bresp", 32'(s_bresp), 32'h2);
            chk("hold_mready", 32'(m_bready), 32'd0);
            step;
        end
        sb.push_back('{10'h3C, 2'b00, 4'h9});
        s_bready = 1'b1;
        #1 chk("hold_rel_mready", 32'(m_bready), 32'd0);
        step;
        chk("after_hold_bid", 32'(s_bid), 32'h3C);
        chk("after_hold_mready", 32'(m_bready), 32'd1);
        step;
        m_bvalid = 1'b0; s_bready = 1'b0;
        chk("cnt_before_clr", 32'(drop_cnt), 32'd8);

        // counter: clear, three pipelined drops, then clear beating an increment
        clr_cnt_i = 1'b1; step; clr_cnt_i = 1'b0;
        chk("clr_cnt", 32'(drop_cnt), 32'd0);
        s_bready = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            set_drop(1'b1, 10'(12'h30 + i), 1'b0, 1'b1);
            sb.push_back('{10'(12'h30 + i), 2'b10, 4'h0});
            step;
            if (i == 2) chk("pushpop_level", 32'(level), 32'd1);
        end
        set_drop(1'b0, 10'h0, 1'b0, 1'b0);
        step;
        chk("cnt3", 32'(drop_cnt), 32'd3);
        chk("cnt3_level", 32'(level), 32'd0);
        chk("sat_cnt3", 32'(sat_cnt), 32'd3);
        set_drop(1'b1, 10'h34, 1'b0, 1'b1);
        sb.push_back('{10'h34, 2'b10, 4'h0});
        step;
        set_drop(1'b0, 10'h0, 1'b0, 1'b0);
        clr_cnt_i = 1'b1;
        step;
        clr_cnt_i = 1'b0;
        chk("clr_priority", 32'(drop_cnt), 32'd0);
        for (int i = 0; i < 5; i++) begin
            set_drop(1'b1, 10'(12'h50 + i), 1'b1, 1'b1);
            sb.push_back('{10'(12'h50 + i), 2'b00, 4'h0});
            step;
        end
        set_drop(1'b0, 10'h0, 1'b0, 1'b0);
        step;
        chk("cnt5", 32'(drop_cnt), 32'd5);
        chk("sat_cnt5", 32'(sat_cnt), 32'd3);
        s_bready = 1'b0;

        // reset while locked on a drop with two entries queued
        set_drop(1'b1, 10'h41, 1'b0, 1'b0); step;
        set_drop(1'b1, 10'h42, 1'b0, 1'b0); step;
        set_drop(1'b0, 10'h0, 1'b0, 1'b0);
        step;
        chk("lock_level", 32'(level), 32'd2);
        #2 axi4_arstn = 1'b0;
        #1;
        chk("mid_rst_level", 32'(level), 32'd0);
        chk("mid_rst_cnt", 32'(drop_cnt), 32'd0);
        chk("mid_rst_bvalid_lo", 32'(s_bvalid), 32'(m_bvalid));
        m_bvalid = 1'b1;
        #1 chk("mid_rst_bvalid_hi", 32'(s_bvalid), 32'd1);
        m_bvalid = 1'b0;
        step;
        axi4_arstn = 1'b1;
        step;
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
